// File: rtl/atm.sv
`default_nettype none
// ============================================================================
// Module   : atm
// Purpose  : ATM transaction controller with a 10-account on-chip database
//            (16-bit PIN, 32-bit unsigned balance per account).
//            A request walks IDLE -> LANG -> ACC_CHECK -> PIN_CHECK and then
//            enters the authenticated state whose code equals the operation.
//            Each action runs once, on the edge that enters its state.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            operation[2:0]  - 3 balance, 4 withdraw, 5 deposit,
//                              6 change PIN, 7 exit, 0-2 no request
//            acc_num[3:0]    - account index (0-9 valid)
//            pin, newPin     - entered PIN / replacement PIN (16 bit)
//            amount[31:0]    - withdraw/deposit amount
//            language        - latched, no functional effect
//            balance[31:0]   - session account balance, 0 outside a session
//            success         - result of the last completed step
//            state[2:0]      - current FSM state code
// Config   : ATM_PIN_CHANGE_EN - when defined, operation 6 / CHANGE_PIN is
//            implemented; otherwise operation 6 is treated as no request.
// Revision : 1.0 - initial release
// ============================================================================
module atm (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  operation,
    input  logic [3:0]  acc_num,
    input  logic [15:0] pin,
    input  logic [15:0] newPin,
    input  logic [31:0] amount,
    input  logic        language,
    output logic [31:0] balance,
    output logic        success,
    output logic [2:0]  state
);

    localparam logic [2:0] S_LANG       = 3'd0;
    localparam logic [2:0] S_ACC_CHECK  = 3'd1;
    localparam logic [2:0] S_PIN_CHECK  = 3'd2;
    localparam logic [2:0] S_BALANCE    = 3'd3;
    localparam logic [2:0] S_WITHDRAW   = 3'd4;
    localparam logic [2:0] S_DEPOSIT    = 3'd5;
    localparam logic [2:0] S_CHANGE_PIN = 3'd6;
    localparam logic [2:0] S_IDLE       = 3'd7;

    localparam int         C_NUM_ACC    = 10;
    localparam logic [3:0] C_MAX_ACC    = 4'd9;
    localparam logic [2:0] C_OP_EXIT    = 3'd7;
`ifdef ATM_PIN_CHANGE_EN
    localparam logic [2:0] C_MAX_OP     = 3'd6;
`else
    localparam logic [2:0] C_MAX_OP     = 3'd5;
`endif

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [15:0] r_pin [C_NUM_ACC];
    logic [31:0] r_bal [C_NUM_ACC];
    logic [3:0]  r_acc;
    logic        r_lang;
    logic        r_success;

    logic        w_req;
    logic [2:0]  w_dispatch;
    logic        w_in_session;
    logic        w_enter;
    logic [31:0] w_cur_bal;
    logic [15:0] w_cur_pin;

    // r_acc is only ever loaded with a checked index, so it stays in range.
    assign w_cur_bal    = r_bal[r_acc];
    assign w_cur_pin    = r_pin[r_acc];

    assign w_req        = (operation >= S_BALANCE) && (operation <= C_MAX_OP);
    // Session routing: a real request selects its state, exit leaves, and
    // anything else (0-2, or a disabled op) falls back to BALANCE.
    assign w_dispatch   = (operation == C_OP_EXIT) ? S_IDLE :
                          w_req                    ? operation : S_BALANCE;
    assign w_in_session = (r_state >= S_BALANCE) && (r_state <= S_CHANGE_PIN);
    // The action fires only on the edge that enters an authenticated state
    // from a different state; holding an operation does not repeat it.
    assign w_enter      = (w_next != r_state) &&
                          (w_next >= S_BALANCE) && (w_next <= S_CHANGE_PIN);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       w_next = w_req ? S_LANG : S_IDLE;
            S_LANG:       w_next = S_ACC_CHECK;
            S_ACC_CHECK:  w_next = (acc_num <= C_MAX_ACC) ? S_PIN_CHECK : S_IDLE;
            S_PIN_CHECK:  w_next = (pin == w_cur_pin) ? w_dispatch : S_IDLE;
            S_BALANCE,
            S_WITHDRAW,
            S_DEPOSIT,
            S_CHANGE_PIN: w_next = w_dispatch;
            default:      w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ database/actions
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NUM_ACC; i++) begin
                // PIN digits i,i+1,i+2,i+3 equal 1111*i + 123 for i = 0..6.
                r_pin[i] <= (i < 7) ? 16'(1111 * i + 123) : 16'd9999;
                r_bal[i] <= 32'd1000;
            end
            r_acc     <= '0;
            r_lang    <= 1'b0;
            r_success <= 1'b0;
        end else begin
            if (r_state == S_LANG) begin
                r_lang <= language;
            end
            if (r_state == S_ACC_CHECK) begin
                if (acc_num <= C_MAX_ACC) begin
                    r_acc <= acc_num;
                end else begin
                    r_success <= 1'b0;
                end
            end
            if ((r_state == S_PIN_CHECK) && (pin != w_cur_pin)) begin
                r_success <= 1'b0;
            end
            if (w_in_session && (w_next == S_IDLE)) begin
                r_acc <= '0;
            end
            if (w_enter) begin
                case (w_next)
                    S_BALANCE: r_success <= 1'b1;
                    S_WITHDRAW: begin
                        if (amount <= w_cur_bal) begin
                            r_bal[r_acc] <= w_cur_bal - amount;
                            r_success    <= 1'b1;
                        end else begin
                            r_success    <= 1'b0;
                        end
                    end
                    S_DEPOSIT: begin
                        r_bal[r_acc] <= w_cur_bal + amount;
                        r_success    <= 1'b1;
                    end
`ifdef ATM_PIN_CHANGE_EN
                    S_CHANGE_PIN: begin
                        r_pin[r_acc] <= newPin;
                        r_success    <= 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        state   = r_state;
        success = r_success;
        balance = '0;
        if (w_in_session) begin
            balance = w_cur_bal;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atm.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm
// Purpose  : Self-checking bench for atm. Directed scenarios followed by
//            randomized sessions, compared against an account-level model
//            (PIN/balance arrays plus the current session operation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  operation;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [15:0] newPin;
    logic [31:0] amount;
    logic        language;
    logic [31:0] balance;
    logic        success;
    logic [2:0]  state;

`ifdef ATM_PIN_CHANGE_EN
    localparam int C_MAX_OP = 6;
`else
    localparam int C_MAX_OP = 5;
`endif

    int          total = 0;
    int          bad   = 0;

    logic [15:0] m_pin [10];
    logic [31:0] m_bal [10];
    int          m_acc;
    int          m_cur;
    bit          m_in;
    bit          m_succ;

    atm dut (
        .clk       (clk),
        .rst       (rst),
        .operation (operation),
        .acc_num   (acc_num),
        .pin       (pin),
        .newPin    (newPin),
        .amount    (amount),
        .language  (language),
        .balance   (balance),
        .success   (success),
        .state     (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bit valid_req(input int op);
        return (op >= 3) && (op <= C_MAX_OP);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_pin[i] = (i < 7) ? 16'(i * 1000 + (i + 1) * 100 + (i + 2) * 10 + (i + 3))
                               : 16'd9999;
            m_bal[i] = 32'd1000;
        end
        m_in   = 1'b0;
        m_succ = 1'b0;
        m_cur  = -1;
        m_acc  = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        operation = 3'd0;
        step();
        rst = 1'b0;
        model_reset();
        chk("rst_state",   32'(state),   32'd7);
        chk("rst_balance", balance,      32'd0);
        chk("rst_success", 32'(success), 32'd0);
    endtask

    // Model of one in-session request, using the currently driven amount/newPin.
    task automatic apply_op(input int op);
        int eff;
        eff = valid_req(op) ? op : 3;
        if (eff != m_cur) begin
            case (eff)
                3: m_succ = 1'b1;
                4: begin
                    if (amount <= m_bal[m_acc]) begin
                        m_bal[m_acc] = m_bal[m_acc] - amount;
                        m_succ = 1'b1;
                    end else begin
                        m_succ = 1'b0;
                    end
                end
                5: begin
                    m_bal[m_acc] = m_bal[m_acc] + amount;
                    m_succ = 1'b1;
                end
                default: begin
                    m_pin[m_acc] = newPin;
                    m_succ = 1'b1;
                end
            endcase
            m_cur = eff;
        end
    endtask

    task automatic check_session(input string tag);
        chk({tag, "_state"},   32'(state),   32'(m_cur));
        chk({tag, "_balance"}, balance,      m_bal[m_acc]);
        chk({tag, "_success"}, 32'(success), 32'(m_succ));
    endtask

    task automatic login(input int acc, input int p, input int op,
                         input logic [31:0] amt, input logic [15:0] np);
        acc_num   = 4'(acc);
        pin       = 16'(p);
        operation = 3'(op);
        amount    = amt;
        newPin    = np;
        language  = 1'($urandom_range(0, 1));
        step();
        if (!valid_req(op)) begin
            chk("idle_hold", 32'(state), 32'd7);
            return;
        end
        chk("lang_state", 32'(state), 32'd0);
        chk("lang_balance", balance, 32'd0);
        step();
        chk("acc_state", 32'(state), 32'd1);
        step();
        if (acc > 9) begin
            m_succ = 1'b0;
            chk("badacc_state",   32'(state),   32'd7);
            chk("badacc_success", 32'(success), 32'd0);
            return;
        end
        chk("pin_state", 32'(state), 32'd2);
        step();
        if (16'(p) != m_pin[acc]) begin
            m_succ = 1'b0;
            chk("badpin_state",   32'(state),   32'd7);
            chk("badpin_success", 32'(success), 32'd0);
            return;
        end
        m_acc = acc;
        m_in  = 1'b1;
        m_cur = -1;
        apply_op(op);
        check_session("entry");
    endtask

    task automatic sess(input int op, input logic [31:0] amt, input logic [15:0] np);
        operation = 3'(op);
        amount    = amt;
        newPin    = np;
        acc_num   = 4'($urandom_range(0, 15));
        pin       = 16'($urandom_range(0, 65535));
        step();
        if (op == 7 || !m_in) begin
            m_in  = 1'b0;
            m_cur = -1;
            chk("exit_state",   32'(state),   32'd7);
            chk("exit_balance", balance,      32'd0);
            chk("exit_success", 32'(success), 32'(m_succ));
        end else begin
            apply_op(op);
            check_session("sess");
        end
    endtask

    initial begin
        int acc, p, op, n;
        logic [31:0] amt;
        rst = 1'b1; operation = '0; acc_num = '0; pin = '0; newPin = '0;
        amount = '0; language = 1'b0;
        model_reset();

        do_reset();

        // Balance inquiry, then a held deposit that must apply only once.
        login(1, 1234, 3, 0, 0);
        for (int i = 0; i < 4; i++) sess(5, 32'd1000, 0);
        chk("deposit_once", balance, 32'd2000);
        sess(3, 0, 0);
        sess(7, 0, 0);

        // Bad PIN then correct retry.
        login(2, 1111, 3, 0, 0);
        login(2, 2345, 3, 0, 0);
        chk("retry_balance", balance, 32'd1000);
        sess(7, 0, 0);

        // Bad account index.
        login(12, 0, 3, 0, 0);

        // Withdraw bounds on a fresh database.
        do_reset();
        login(1, 1234, 4, 32'd1500, 0);
        chk("overdraw_success", 32'(success), 32'd0);
        sess(3, 0, 0);
        sess(4, 32'd400, 0);
        chk("withdraw_balance", balance, 32'd600);
        sess(4, 32'd1000, 0);
        sess(4, 32'd600, 0);
        sess(0, 0, 0);
        sess(4, 32'd600, 0);
        chk("withdraw_all", balance, 32'd0);
        sess(5, 32'hFFFF_FFFF, 0);
        sess(3, 0, 0);
        sess(5, 32'd2, 0);
        chk("deposit_wrap", balance, 32'd1);
        sess(7, 0, 0);

        // PIN change (acts as BALANCE when the feature is not built).
        login(1, 1234, 3, 0, 0);
        sess(6, 0, 16'd4321);
        sess(7, 0, 0);
        login(1, 1234, 3, 0, 0);
        sess(7, 0, 0);
        login(1, 4321, 3, 0, 0);
        sess(7, 0, 0);
        do_reset();
        login(1, 1234, 3, 0, 0);
        sess(7, 0, 0);

        // Reset mid-session aborts and restores the database.
        login(0, 123, 5, 32'd50, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        chk("midrst_state",   32'(state),   32'd7);
        chk("midrst_balance", balance,      32'd0);
        chk("midrst_success", 32'(success), 32'd0);
        login(0, 123, 3, 0, 0);
        chk("midrst_restored", balance, 32'd1000);
        sess(7, 0, 0);

        // Randomized sessions.
        for (int it = 0; it < 40; it++) begin
            acc = $urandom_range(0, 11);
            if (acc <= 9 && $urandom_range(0, 3) != 0) p = int'(m_pin[acc]);
            else p = $urandom_range(0, 65535);
            op  = $urandom_range(3, 6);
            amt = $urandom_range(0, 1500);
            login(acc, p, op, amt, 16'($urandom_range(0, 65535)));
            if (m_in) begin
                n = $urandom_range(1, 6);
                for (int k = 0; k < n; k++) begin
                    op  = $urandom_range(0, 6);
                    amt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255))
                                                      : 32'($urandom_range(0, 2000));
                    sess(op, amt, 16'($urandom_range(0, 65535)));
                end
            end
            sess(7, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atm.md
# atm

Single-clock ATM transaction controller holding a small on-chip account database of 10 accounts, each with a PIN and a balance. It takes a customer request (language, account number, PIN, operation, amount, new PIN), authenticates over a fixed sequence of states and then performs balance inquiry, withdrawal, deposit or PIN change. It sits between the user-interface front end and the display/cash-dispense logic.

## Interface
- No parameters. Fixed sizes: 10 accounts, 16-bit PINs, 32-bit unsigned balances.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- operation  input  3  request: 3 balance, 4 withdraw, 5 deposit, 6 change PIN, 7 exit; 0–2 no request
- acc_num  input  4  account index; valid range 0–9
- pin  input  16  entered PIN, binary
- newPin  input  16  replacement PIN for operation 6
- amount  input  32  withdraw/deposit amount, unsigned
- language  input  1  language select; latched, no functional effect
- balance  output  32  balance of the session account; 0 when no session
- success  output  1  1 = last completed step succeeded
- state  output  3  current FSM state code

## Operation
- Reset database: account i has PIN with decimal digits i,i+1,i+2,i+3 (acc 0 = 123, acc 1 = 1234, acc 2 = 2345, …, acc 6 = 6789), balance 1000. Accounts 7–9 use PIN 9999.
- States: 7 IDLE, 0 LANG, 1 ACC_CHECK, 2 PIN_CHECK, 3 BALANCE, 4 WITHDRAW, 5 DEPOSIT, 6 CHANGE_PIN.
- IDLE: if operation is 3–6, go to LANG; otherwise stay in IDLE.
- LANG: latch language; go to ACC_CHECK.
- ACC_CHECK: if acc_num ≤ 9, latch it as the session account and go to PIN_CHECK. Otherwise go to IDLE with success=0.
- PIN_CHECK: if pin equals the stored PIN, go to the state whose code equals operation. Otherwise go to IDLE with success=0.
- Authenticated states (3–6):
  - The action executes once, on the edge that enters the state from a different state.
  - Holding the same operation keeps the state and does not repeat the action.
  - A different operation 3–6 moves directly to that state, with no re-authentication.
  - Operation 7 ends the session and goes to IDLE.
  - Operation 0–2 moves to BALANCE.
  - acc_num and pin changes are ignored; the session account stays locked until exit or rst.
- Actions:
  - BALANCE: success=1.
  - DEPOSIT: balance += amount, wrapping mod 2^32; success=1.
  - WITHDRAW: if amount ≤ balance, subtract it with success=1. Otherwise balance is unchanged and success=0.
  - CHANGE_PIN: stored PIN = newPin; success=1.
- Outputs are registered. balance shows the session account's stored balance in states 3–6 and 0 otherwise.

## Timing
- Reset, checked at the clock edge: state=7, success=0, balance=0, database reloaded, session cleared. rst asserted mid-session aborts on that edge.
- Latency from IDLE with a valid request held: 4 edges until state equals the operation code (7→0→1→2→op).
- The action's result (balance, success) is visible right after the entry edge.
- An operation switch inside a session takes 1 edge.
- Failed account or PIN check: IDLE plus success=0 one edge after the check state.

## Configuration
- ATM_PIN_CHANGE_EN:
  - Defined: operation 6 and the CHANGE_PIN state are implemented as above.
  - Undefined: operation 6 is treated as "no request". It does not start a session from IDLE, it moves to BALANCE inside a session, and stored PINs are never modified.

## Test plan
- Reset: rst=1 for one edge, then released → state=7, balance=0, success=0.
- Balance inquiry: from IDLE, op=3, acc=1, pin=1234 held → state 7,0,1,2,3 over 4 edges; balance=1000, success=1.
- Single deposit: in session, op=5, amount=1000 held 4 cycles → state=5, balance=2000 after the first edge and still 2000 after cycles 2–4. Then op=3 → state=3 next edge, balance=2000.
- Bad PIN: acc=2, pin=1111, op=3 → state reaches 2, then 7 with success=0. Retry with pin=2345 → state=3, balance=1000.
- Withdraw bounds: acc=1 session, op=4, amount=1500 → success=0, balance=1000. Then op=3, then op=4, amount=400 → balance=600, success=1.
- PIN change (macro defined): acc=1, op=6, newPin=4321, then op=7. Login with 1234 fails to IDLE; login with 4321 reaches state 3. rst restores PIN 1234.
